// File: rtl/z80_bus_pkg.sv
// Shared Z80 bus types: master/slave bus structs, machine-cycle state enum, bus widths.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package z80_bus_pkg;

   localparam int Z80_ADDR_W = 16;
   localparam int Z80_DATA_W = 8;

   // Fields driven by the bus master towards all slaves
   typedef struct packed {
      logic [Z80_ADDR_W-1:0] addr;
      logic [Z80_DATA_W-1:0] dmaster;
      logic                  mreq_n;
      logic                  iorq_n;
      logic                  rd_n;
      logic                  wr_n;
   } Z80MasterBus;

   // Fields returned by the selected slave; mwait = 0 requests a wait state
   typedef struct packed {
      logic [Z80_DATA_W-1:0] dslave;
      logic                  mwait;
   } Z80SlaveBus;

   typedef enum logic [2:0] {
      IDLE,
      T1,
      T2,
      TW,
      T3
   } z80_mcycle_e;

endpackage

// File: rtl/z80_wait_timer.sv
// Wait-state timer: counts consecutive TW cycles and flags the terminal count.
// Latency: tc is registered-count based, valid in the same cycle as the count.
// Backpressure: none; clr has priority over inc.
module z80_wait_timer #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic inc,
   output logic tc
);

   logic [15:0] cnt_q;
   logic [15:0] cnt_d;

   // Clear while in T2 so the first TW sees zero; count one per TW cycle
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = 16'h0000;
      end else if (inc) begin
         cnt_d = cnt_q + 16'd1;
      end
   end

   // Counter register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= 16'h0000;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Count holds the number of completed TW cycles, so the last allowed TW sees TIMEOUT_CYCLES-1
   assign tc = (cnt_q == 16'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/z80_bus_master.sv
// Z80 bus master: single-beat host request -> memory or I/O machine cycle (optional TW timeout: Z80_BUS_MASTER_TIMEOUT_EN).
// Latency: accept at edge N, T1..T3 in N+1..N+3, rsp_valid in N+4; each TW adds one cycle.
// Backpressure: req_ready only in IDLE; rsp_valid is a one-cycle pulse and cannot be stalled.
module z80_bus_master
   import z80_bus_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic                  req_io,
   input  logic [Z80_ADDR_W-1:0] req_addr,
   input  logic [Z80_DATA_W-1:0] req_wdata,
   output logic                  rsp_valid,
   output logic [Z80_DATA_W-1:0] rsp_rdata,
   output logic                  rsp_err,
   output logic                  ena,
   output Z80MasterBus           obus,
   input  Z80SlaveBus            ibus
);

   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be in 1..65535");
   end

   z80_mcycle_e           state_q, state_d;
   logic [Z80_ADDR_W-1:0] addr_q, addr_d;
   logic [Z80_DATA_W-1:0] dmaster_q, dmaster_d;
   logic [Z80_DATA_W-1:0] wdata_q, wdata_d;
   logic [Z80_DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
   logic                  mreq_n_q, mreq_n_d;
   logic                  iorq_n_q, iorq_n_d;
   logic                  rd_n_q, rd_n_d;
   logic                  wr_n_q, wr_n_d;
   logic                  ena_q, ena_d;
   logic                  write_q, write_d;
   logic                  err_q, err_d;
   logic                  rsp_valid_q, rsp_valid_d;
   logic                  rsp_err_q, rsp_err_d;
   logic                  timeout_hit;

`ifdef Z80_BUS_MASTER_TIMEOUT_EN
   z80_wait_timer #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_wait_timer (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (state_q == T2),
      .inc   (state_q == TW),
      .tc    (timeout_hit)
   );
`else
   assign timeout_hit = 1'b0;
`endif

   // Ready is gated by the reset pin so it reads 0 for the whole reset assertion
   assign req_ready = rst_n && (state_q == IDLE);

   // Next-state and next-output logic; all bus outputs come straight from flops
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      dmaster_d   = dmaster_q;
      wdata_d     = wdata_q;
      rsp_rdata_d = rsp_rdata_q;
      mreq_n_d    = mreq_n_q;
      iorq_n_d    = iorq_n_q;
      rd_n_d      = rd_n_q;
      wr_n_d      = wr_n_q;
      ena_d       = ena_q;
      write_d     = write_q;
      err_d       = err_q;
      rsp_valid_d = 1'b0;
      rsp_err_d   = rsp_err_q;
      case (state_q)
         IDLE: begin
            if (req_valid && req_ready) begin
               state_d  = T1;
               addr_d   = req_addr;
               wdata_d  = req_wdata;
               write_d  = req_write;
               err_d    = 1'b0;
               mreq_n_d = req_io;
               iorq_n_d = !req_io;
               rd_n_d   = req_write;
               ena_d    = 1'b1;
               if (!req_write) begin
                  dmaster_d = '0;
               end
            end
         end
         T1: begin
            state_d = T2;
            if (write_q) begin
               dmaster_d = wdata_q;
               wr_n_d    = 1'b0;
            end
         end
         T2: begin
            state_d = ibus.mwait ? T3 : TW;
         end
         TW: begin
            if (ibus.mwait) begin
               state_d = T3;
            end else if (timeout_hit) begin
               state_d = T3;
               err_d   = 1'b1;
            end
         end
         T3: begin
            state_d     = IDLE;
            mreq_n_d    = 1'b1;
            iorq_n_d    = 1'b1;
            rd_n_d      = 1'b1;
            wr_n_d      = 1'b1;
            ena_d       = 1'b0;
            rsp_valid_d = 1'b1;
            rsp_err_d   = err_q;
            rsp_rdata_d = (write_q || err_q) ? '0 : ibus.dslave;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and output registers; reset returns strobes high and drops any cycle in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         dmaster_q   <= '0;
         wdata_q     <= '0;
         rsp_rdata_q <= '0;
         mreq_n_q    <= 1'b1;
         iorq_n_q    <= 1'b1;
         rd_n_q      <= 1'b1;
         wr_n_q      <= 1'b1;
         ena_q       <= 1'b0;
         write_q     <= 1'b0;
         err_q       <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         dmaster_q   <= dmaster_d;
         wdata_q     <= wdata_d;
         rsp_rdata_q <= rsp_rdata_d;
         mreq_n_q    <= mreq_n_d;
         iorq_n_q    <= iorq_n_d;
         rd_n_q      <= rd_n_d;
         wr_n_q      <= wr_n_d;
         ena_q       <= ena_d;
         write_q     <= write_d;
         err_q       <= err_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   assign obus.addr    = addr_q;
   assign obus.dmaster = dmaster_q;
   assign obus.mreq_n  = mreq_n_q;
   assign obus.iorq_n  = iorq_n_q;
   assign obus.rd_n    = rd_n_q;
   assign obus.wr_n    = wr_n_q;
   assign ena          = ena_q;
   assign rsp_valid    = rsp_valid_q;
   assign rsp_rdata    = rsp_rdata_q;
   assign rsp_err      = rsp_err_q;

endmodule

// File: tb/tb_z80_bus_master.sv
// Directed bench for z80_bus_master with a registered ROM/I/O slave model.
// Latency: checks accept+4 responses, TW stretching, 4-cycle back-to-back spacing.
// Backpressure: exercises req_ready gating, reset mid-cycle and the TW timeout build.
module tb_z80_bus_master;
   import z80_bus_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic        req_io;
   logic [15:0] req_addr;
   logic [7:0]  req_wdata;
   logic        rsp_valid;
   logic [7:0]  rsp_rdata;
   logic        rsp_err;
   logic        ena;
   Z80MasterBus obus;
   Z80SlaveBus  ibus;

   int total = 0;
   int bad   = 0;

   z80_bus_master #(.TIMEOUT_CYCLES(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_write (req_write),
      .req_io    (req_io),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),
      .ena       (ena),
      .obus      (obus),
      .ibus      (ibus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // Slave model: ROM bytes, one I/O port, mwait programme counted from T1
   logic [7:0]  rom [12];
   int          wait_plan = 0;
   int          ena_cnt = 0;
   logic        wr_seen = 1'b0;
   logic [15:0] wr_addr_seen = 16'h0;
   logic [7:0]  wr_data_seen = 8'h0;

   always @(negedge clk) begin
      if (ena) ena_cnt = ena_cnt + 1;
      else     ena_cnt = 0;
      ibus.mwait = !(ena_cnt >= 2 && ena_cnt < 2 + wait_plan);
      if (ena && !obus.rd_n) begin
         if (!obus.iorq_n)
            ibus.dslave = (obus.addr == 16'h0010) ? 8'hA5 : 8'hFF;
         else
            ibus.dslave = (obus.addr < 16'd12) ? rom[obus.addr[3:0]] : 8'hFF;
      end
      if (ena && !obus.wr_n && !obus.mreq_n) begin
         wr_seen      = 1'b1;
         wr_addr_seen = obus.addr;
         wr_data_seen = obus.dmaster;
      end
   end

   // Per-cycle logs indexed by k (k=1 is T1)
   logic [15:0] mreq_v, iorq_v, rd_v, wr_v, ena_v;
   logic [7:0]  dm_log [16];

   task automatic run_txn(input logic w, input logic io, input logic [15:0] a, input logic [7:0] wd,
                          output int lat, output logic [7:0] rd, output logic er, output logic rdy);
      int n;
      @(negedge clk);
      req_valid = 1'b1; req_write = w; req_io = io; req_addr = a; req_wdata = wd;
      n = 0;
      while (!req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      @(posedge clk);
      lat = 0; rd = 8'hxx; er = 1'bx; rdy = 1'bx;
      mreq_v = '1; iorq_v = '1; rd_v = '1; wr_v = '1; ena_v = '0;
      for (int k = 1; k <= 60; k++) begin
         @(negedge clk);
         if (k == 1) begin
            req_valid = 1'b0; req_addr = 16'hDEAD; req_wdata = 8'h55; req_write = ~w; req_io = ~io;
         end
         if (k < 16) begin
            mreq_v[k] = obus.mreq_n; iorq_v[k] = obus.iorq_n; rd_v[k] = obus.rd_n;
            wr_v[k] = obus.wr_n; ena_v[k] = ena; dm_log[k] = obus.dmaster;
         end
         if (rsp_valid) begin
            lat = k; rd = rsp_rdata; er = rsp_err; rdy = req_ready;
            break;
         end
      end
      if (lat == 0) check("rsp_wait", rsp_valid, 1'b1);
   endtask

   int          lat;
   logic [7:0]  rd;
   logic        er, rdy;
   int          t, n_acc, n_rsp, rsp_cnt;
   int          acc_t [3];
   logic [7:0]  bb_d [3];
   logic        pend;

   initial begin
      rom[0] = 8'h3E; rom[1] = 8'h20; rom[2]  = 8'h32; rom[3]  = 8'h00;
      rom[4] = 8'h80; rom[5] = 8'h21; rom[6]  = 8'h00; rom[7]  = 8'h80;
      rom[8] = 8'h31; rom[9] = 8'hFF; rom[10] = 8'h76; rom[11] = 8'hF4;
      ibus.dslave = 8'h00; ibus.mwait = 1'b1;
      rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_io = 1'b0;
      req_addr = 16'h0; req_wdata = 8'h0;

      // Reset state
      #12;
      check("rst_ready", req_ready, 1'b0);
      check("rst_strobes", {obus.mreq_n, obus.iorq_n, obus.rd_n, obus.wr_n}, 4'hF);
      check("rst_addr", obus.addr, 16'h0000);
      check("rst_dmaster", obus.dmaster, 8'h00);
      check("rst_ena", ena, 1'b0);
      check("rst_rsp", {rsp_valid, rsp_err}, 2'b00);
      check("rst_rdata", rsp_rdata, 8'h00);
      @(negedge clk); rst_n = 1'b1; #1;
      check("rel_ready", req_ready, 1'b1);

      // Memory read 0x0000, no waits
      run_txn(1'b0, 1'b0, 16'h0000, 8'h00, lat, rd, er, rdy);
      check("rd0_lat", lat, 4);
      check("rd0_data", rd, 8'h3E);
      check("rd0_err", er, 1'b0);
      check("rd0_ready", rdy, 1'b1);
      check("rd0_mreq", mreq_v[4:1], 4'b1000);
      check("rd0_rd", rd_v[4:1], 4'b1000);
      check("rd0_ena", ena_v[4:1], 4'b0111);
      @(negedge clk);
      check("rd0_pulse", rsp_valid, 1'b0);

      // Memory read 0x000B
      run_txn(1'b0, 1'b0, 16'h000B, 8'h00, lat, rd, er, rdy);
      check("rdB_data", rd, 8'hF4);
      check("rdB_lat", lat, 4);

      // Memory write 0x8000 <- 0x20
      run_txn(1'b1, 1'b0, 16'h8000, 8'h20, lat, rd, er, rdy);
      check("wr_lat", lat, 4);
      check("wr_rdata", rd, 8'h00);
      check("wr_mreq", mreq_v[4:1], 4'b1000);
      check("wr_wr", wr_v[4:1], 4'b1001);
      check("wr_rd", rd_v[4:1], 4'b1111);
      check("wr_dm_t2", dm_log[2], 8'h20);
      check("wr_dm_hold", dm_log[4], 8'h20);
      check("wr_slave", {wr_seen, wr_addr_seen, wr_data_seen}, {1'b1, 16'h8000, 8'h20});

      // I/O read of port 0x0010 with three wait samples
      wait_plan = 3;
      run_txn(1'b0, 1'b1, 16'h0010, 8'h00, lat, rd, er, rdy);
      check("io_lat", lat, 7);
      check("io_data", rd, 8'hA5);
      check("io_iorq", iorq_v[7:1], 7'b1000000);
      check("io_mreq", mreq_v[7:1], 7'b1111111);
      check("io_dm_read", dm_log[1], 8'h00);
      wait_plan = 0;

      // Back-to-back reads with req_valid held high
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b0; req_io = 1'b0; req_addr = 16'h0000;
      t = 0; n_acc = 0; n_rsp = 0; pend = 1'b0;
      while (n_rsp < 3 && t < 80) begin
         t++;
         if (pend) begin
            pend = 1'b0;
            if (n_acc < 3) req_addr = 16'(n_acc);
            else           req_valid = 1'b0;
         end
         if (rsp_valid) begin
            bb_d[n_rsp] = rsp_rdata;
            n_rsp++;
         end
         if (n_acc < 3 && req_valid && req_ready) begin
            acc_t[n_acc] = t;
            n_acc++;
            pend = 1'b1;
         end
         @(negedge clk);
      end
      req_valid = 1'b0;
      check("b2b_nrsp", n_rsp, 3);
      check("b2b_gap1", acc_t[1] - acc_t[0], 4);
      check("b2b_gap2", acc_t[2] - acc_t[1], 4);
      check("b2b_d0", bb_d[0], 8'h3E);
      check("b2b_d1", bb_d[1], 8'h20);
      check("b2b_d2", bb_d[2], 8'h32);

`ifdef Z80_BUS_MASTER_TIMEOUT_EN
      // mwait stuck low: abort after four TW cycles
      wait_plan = 1000;
      run_txn(1'b0, 1'b0, 16'h0000, 8'h00, lat, rd, er, rdy);
      check("to_lat", lat, 8);
      check("to_err", er, 1'b1);
      check("to_rdata", rd, 8'h00);
      check("to_ready", rdy, 1'b1);
      check("to_ena", ena_v[8:1], 8'h7F);
      wait_plan = 0;
`else
      // Without the timeout a long wait simply stretches the cycle
      wait_plan = 10;
      run_txn(1'b0, 1'b0, 16'h0000, 8'h00, lat, rd, er, rdy);
      check("lw_lat", lat, 14);
      check("lw_err", er, 1'b0);
      check("lw_data", rd, 8'h3E);
      check("lw_ready", rdy, 1'b1);
      wait_plan = 0;
`endif

      // Reset pulsed during TW
      wait_plan = 100;
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b0; req_io = 1'b0; req_addr = 16'h0001;
      t = 0;
      while (!req_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      @(posedge clk);
      @(negedge clk); req_valid = 1'b0;
      repeat (3) @(negedge clk);
      check("mid_in_cycle", {ena, obus.rd_n}, 2'b10);
      rst_n = 1'b0; #1;
      check("mid_strobes", {obus.mreq_n, obus.iorq_n, obus.rd_n, obus.wr_n}, 4'hF);
      check("mid_ena", ena, 1'b0);
      check("mid_ready", req_ready, 1'b0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1; wait_plan = 0; #1;
      check("mid_rel_ready", req_ready, 1'b1);
      rsp_cnt = 0;
      repeat (6) begin
         @(negedge clk);
         if (rsp_valid) rsp_cnt++;
      end
      check("mid_no_rsp", rsp_cnt, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
